seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Downstream consumer of the memory-mapped IO write register, the 16-bit value latched on IO-space stores.
- Displays that value as 4 hex digits on a time-multiplexed, common-anode 7-segment display.
- Contains a refresh prescaler, a digit scan counter, a frame-synchronous shadow register (tear-free updates), optional leading-zero blanking and registered outputs.

Parameters:
- DATA_WIDTH, 16, width of value input; fixed at 4 hex digits, so must be 16.
- REFRESH_DIV, 50000, clk cycles per digit slot; minimum 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  DATA_WIDTH  IO output register contents to display.
- enable  input  1  1 = display on; 0 = all digits dark.
- blank_leading  input  1  1 = suppress leading zero digits.
- dp_mask  input  4  decimal point on for digit i when bit i = 1.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit anodes, active-low; an[0] = least-significant nibble.

Behaviour:
- Reset (async, immediate):
  - prescaler = 0, digit_idx = 0, shadow = 0.
  - seg = 7'h7F, dp = 1, an = 4'hF (all dark).
- Prescaler:
  - Width max(1, clog2(REFRESH_DIV)); counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = 1 in the cycle prescaler == REFRESH_DIV-1.
  - REFRESH_DIV = 1 gives tick every cycle.
- Digit counter:
  - 2-bit digit_idx increments on tick, wrapping 3 -> 0.
- Shadow capture:
  - On a tick where digit_idx == 3 (frame wrap), shadow <= value, sampled in that same cycle.
  - value changes mid-frame are never shown until the next frame.
  - Simultaneous value change and wrap tick: the new value is captured.
- Counters and capture run regardless of enable.
- Output register (one-cycle latency from digit_idx/shadow/enable/blank_leading/dp_mask):
  - an = ~(4'b0001 << digit_idx) when enable = 1 and the digit is not blanked; otherwise 4'hF.
  - seg = hex decode of shadow nibble digit_idx; 7'h7F when dark.
  - dp = ~dp_mask[digit_idx] when lit; 1 when dark.
- Leading-zero blanking (blank_leading = 1):
  - Digit i (i = 3..1) is blanked iff all shadow nibbles i..3 are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted mid-frame: all state clears at once, outputs go dark. After release, scanning restarts at digit 0 showing shadow = 0 until the first frame wrap.
- enable toggling: no effect on scan phase; the blank/unblank decision lands on the next clock edge.

Decomposition:
- Shared package/include holds:
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 4'hF.
  - The 16-entry hex segment constants.
  - NUM_DIGITS = 4.
- Natural sub-module: hex_to_seg7, a combinational 4-bit nibble -> 7-bit active-low pattern. Instantiated once and muxed by digit_idx.

Test Plan (REFRESH_DIV = 4):
- Reset check: reset high mid-scan -> same-cycle seg = 7F, an = F, dp = 1. Release, value = 16'h0000, enable = 1 -> first edge an = E, seg = 40.
- Scan and capture: value = 16'h12AF held from reset release -> after the first frame wrap (cycle 16), successive 4-cycle slots show:
  - an = E, seg = 0E ("F")
  - an = D, seg = 08 ("A")
  - an = B, seg = 24 ("2")
  - an = 7, seg = 79 ("1")
  - Order repeats every 16 cycles.
- Tear-free: value changes 12AF -> 3456 while digit_idx = 1 -> digits 2 and 3 still show 2 and 1 this frame. The next frame shows 6, 5, 4, 3.
- Leading-zero blanking: blank_leading = 1, value = 16'h0007 -> only the an = E slot lights (seg = 78); other slots an = F. value = 16'h0000 -> digit 0 shows 40, others dark.
- Enable and dp: dp_mask = 4'b0100 -> dp = 0 only in the an = B slot. Drop enable -> next edge an = F, seg = 7F, dp = 1. Scan phase is unchanged when enable returns.
- REFRESH_DIV = 1 build: digit_idx advances every cycle; an sequence E, D, B, 7 on consecutive cycles.

Source files
------------

// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the multiplexed 4-digit hex display: blank patterns,
// digit count, the active-low segment table and the prescaler width helper.
package seven_seg_scan_pkg;

   localparam int NUM_DIGITS = 4;

   // All segments off (active-low) and all anodes off (active-low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;

   // Prescaler width: max(1, clog2(div)), so a divide-by-1 still has a bit
   function automatic int presc_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg7
   import seven_seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Map the nibble onto its hex glyph
   always_comb begin
      // NOTE: default assignment first so no path through the block leaves seg_n unassigned (no latch).
      seg_n = SEG_BLANK;
      unique case (nibble)
         4'h0: seg_n = SEG_HEX_0;
         4'h1: seg_n = SEG_HEX_1;
         4'h2: seg_n = SEG_HEX_2;
         4'h3: seg_n = SEG_HEX_3;
         4'h4: seg_n = SEG_HEX_4;
         4'h5: seg_n = SEG_HEX_5;
         4'h6: seg_n = SEG_HEX_6;
         4'h7: seg_n = SEG_HEX_7;
         4'h8: seg_n = SEG_HEX_8;
         4'h9: seg_n = SEG_HEX_9;
         4'hA: seg_n = SEG_HEX_A;
         4'hB: seg_n = SEG_HEX_B;
         4'hC: seg_n = SEG_HEX_C;
         4'hD: seg_n = SEG_HEX_D;
         4'hE: seg_n = SEG_HEX_E;
         4'hF: seg_n = SEG_HEX_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit hex display driver for a common-anode 7-segment
// module. The value is copied into a shadow register only at frame wrap, so a
// frame never mixes digits of two different values.
module seven_seg_scan
   import seven_seg_scan_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  enable,
   input  logic                  blank_leading,
   input  logic [3:0]            dp_mask,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [3:0]            an
);

   localparam int                 PRESC_W   = presc_width(REFRESH_DIV);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [1:0]            digit_idx_q, digit_idx_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [3:0]            an_q, an_d;

   logic                  tick;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;
   logic [NUM_DIGITS-1:0] nib_zero;
   logic [NUM_DIGITS-1:0] blank;
   logic                  lit;

   // Single decoder, fed with the nibble of the digit currently being scanned
   assign nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg_n  (seg_dec)
   );

   // Prescaler, scan counter and frame-synchronous shadow capture
   always_comb begin
      tick        = (presc_q == PRESC_MAX);
      presc_d     = tick ? '0 : presc_q + 1'b1;
      digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;
      shadow_d    = (tick && (digit_idx_q == 2'd3)) ? value : shadow_q;
   end

   // Leading-zero blanking and output pattern selection
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib_zero[i] = (shadow_q[4*i +: 4] == 4'h0);
      end
      // Digit 0 always shows, so a zero value still displays "0"
      blank = {blank_leading & nib_zero[3],
               blank_leading & (&nib_zero[3:2]),
               blank_leading & (&nib_zero[3:1]),
               1'b0};
      lit   = enable && !blank[digit_idx_q];
      an_d  = lit ? ~(4'b0001 << digit_idx_q) : AN_OFF;
      seg_d = lit ? seg_dec : SEG_BLANK;
      dp_d  = lit ? ~dp_mask[digit_idx_q] : 1'b1;
   end

   // State and registered outputs; reset darkens the display immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         digit_idx_q <= '0;
         shadow_q    <= '0;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
         an_q        <= AN_OFF;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         presc_q     <= presc_d;
         digit_idx_q <= digit_idx_d;
         shadow_q    <= shadow_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         an_q        <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: expected display patterns are queued as
// stimulus is applied and compared against the DUT after each clock edge.
module tb_seven_seg_scan;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   logic        clk = 1'b0;
   logic        reset, reset_f;
   logic [15:0] value, value_f;
   logic        enable, blank_leading;
   logic [3:0]  dp_mask;
   logic [6:0]  seg, seg_f;
   logic        dp, dp_f;
   logic [3:0]  an, an_f;

   disp_t sb[$];
   int    vectors     = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   seven_seg_scan #(.DATA_WIDTH(16), .REFRESH_DIV(4)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .value         (value),
      .enable        (enable),
      .blank_leading (blank_leading),
      .dp_mask       (dp_mask),
      .seg           (seg),
      .dp            (dp),
      .an            (an)
   );

   seven_seg_scan #(.DATA_WIDTH(16), .REFRESH_DIV(1)) u_fast (
      .clk           (clk),
      .reset         (reset_f),
      .value         (value_f),
      .enable        (1'b1),
      .blank_leading (1'b0),
      .dp_mask       (4'b0000),
      .seg           (seg_f),
      .dp            (dp_f),
      .an            (an_f)
   );

   // Pop the oldest expectation and compare it with the observed outputs
   task automatic compare(input string tag, input logic [3:0] an_o,
                          input logic [6:0] seg_o, input logic dp_o);
      disp_t exp;
      disp_t obs;
      exp = sb.pop_front();
      obs = '{an: an_o, seg: seg_o, dp: dp_o};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                tag, obs.an, obs.seg, obs.dp, exp.an, exp.seg, exp.dp);
      end
   endtask

   // Check the main DUT right now, without a clock edge
   task automatic expect_now(input logic [3:0] an_e, input logic [6:0] seg_e,
                             input logic dp_e, input string tag);
      sb.push_back('{an: an_e, seg: seg_e, dp: dp_e});
      compare(tag, an, seg, dp);
   endtask

   // Expect the main DUT to show one pattern for n consecutive edges
   task automatic slot(input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         sb.push_back('{an: an_e, seg: seg_e, dp: dp_e});
         @(posedge clk);
         #1;
         compare(tag, an, seg, dp);
      end
   endtask

   // One edge of the divide-by-1 instance
   task automatic fast_cycle(input logic [3:0] an_e, input logic [6:0] seg_e,
                             input string tag);
      sb.push_back('{an: an_e, seg: seg_e, dp: 1'b1});
      @(posedge clk);
      #1;
      compare(tag, an_f, seg_f, dp_f);
   endtask

   initial begin
      reset = 1'b1; reset_f = 1'b1;
      value = 16'h0000; value_f = 16'h12AF;
      enable = 1'b1; blank_leading = 1'b0; dp_mask = 4'b0000;

      // Reset state, then scanning from digit 0 with a zero shadow
      @(posedge clk); #1;
      expect_now(4'hF, 7'h7F, 1'b1, "reset_idle");
      reset = 1'b0;
      slot(4'hE, 7'h40, 1'b1, 4, "zero_d0");
      slot(4'hD, 7'h40, 1'b1, 2, "zero_d1");

      // Asynchronous reset mid-scan darkens the outputs at once
      reset = 1'b1;
      #1;
      expect_now(4'hF, 7'h7F, 1'b1, "reset_async");
      slot(4'hF, 7'h7F, 1'b1, 1, "reset_held");

      // Frame 0 still shows the cleared shadow; 12AF is captured at the wrap
      value = 16'h12AF;
      reset = 1'b0;
      slot(4'hE, 7'h40, 1'b1, 4, "f0_d0");
      slot(4'hD, 7'h40, 1'b1, 4, "f0_d1");
      slot(4'hB, 7'h40, 1'b1, 4, "f0_d2");
      slot(4'h7, 7'h40, 1'b1, 4, "f0_d3");
      slot(4'hE, 7'h0E, 1'b1, 4, "scan_F");

      // Mid-frame value change must not tear the current frame
      value = 16'h3456;
      slot(4'hD, 7'h08, 1'b1, 4, "tear_A");
      slot(4'hB, 7'h24, 1'b1, 4, "tear_2");
      slot(4'h7, 7'h79, 1'b1, 4, "tear_1");
      slot(4'hE, 7'h02, 1'b1, 4, "new_6");

      // Leading-zero blanking, armed mid-frame on a nonzero shadow
      value = 16'h0007;
      blank_leading = 1'b1;
      slot(4'hD, 7'h12, 1'b1, 4, "new_5");
      slot(4'hB, 7'h19, 1'b1, 4, "new_4");
      slot(4'h7, 7'h30, 1'b1, 4, "new_3");
      slot(4'hE, 7'h78, 1'b1, 4, "blank7_d0");
      value = 16'h0000;
      slot(4'hF, 7'h7F, 1'b1, 12, "blank7_dark");
      slot(4'hE, 7'h40, 1'b1, 4, "blank0_d0");
      value = 16'h12AF;
      slot(4'hF, 7'h7F, 1'b1, 12, "blank0_dark");

      // Decimal point on digit 2 only
      blank_leading = 1'b0;
      dp_mask = 4'b0100;
      slot(4'hE, 7'h0E, 1'b1, 4, "dp_d0");
      slot(4'hD, 7'h08, 1'b1, 4, "dp_d1");
      slot(4'hB, 7'h24, 1'b0, 4, "dp_d2");
      slot(4'h7, 7'h79, 1'b1, 4, "dp_d3");

      // Enable drop mid-slot: dark on the next edge, scan phase preserved
      slot(4'hE, 7'h0E, 1'b1, 2, "en_before");
      enable = 1'b0;
      slot(4'hF, 7'h7F, 1'b1, 4, "en_off");
      enable = 1'b1;
      slot(4'hD, 7'h08, 1'b1, 2, "en_back_d1");
      slot(4'hB, 7'h24, 1'b0, 4, "en_back_d2");

      // Divide-by-1 build advances one digit per clock
      reset_f = 1'b0;
      fast_cycle(4'hE, 7'h40, "fast_d0");
      fast_cycle(4'hD, 7'h40, "fast_d1");
      fast_cycle(4'hB, 7'h40, "fast_d2");
      fast_cycle(4'h7, 7'h40, "fast_d3");
      fast_cycle(4'hE, 7'h0E, "fast_F");
      fast_cycle(4'hD, 7'h08, "fast_A");
      fast_cycle(4'hB, 7'h24, "fast_2");
      fast_cycle(4'h7, 7'h79, "fast_1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Run-time guard in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
